// File: rtl/lzc_pipe_if.sv
// Valid/ready operand channel and result channel of lzc_pipe.
// The slave modport is the pipeline; master is the producer/consumer side.
interface lzc_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_cnt;
  logic             out_zero;
  logic [WIDTH-1:0] out_norm;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_cnt, out_zero, out_norm
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_cnt, out_zero, out_norm
  );
endinterface

// File: rtl/lzc_pipe.sv
// Two-stage leading-zero / redundant-sign-bit counter with optional normaliser.
// Define LZC_PIPE_NORM_EN to build the left-normalising barrel shifter on out_norm.
module lzc_pipe #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input logic       clk,
  input logic       reset_n,
  lzc_pipe_if.slave bus
);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int NG  = (WIDTH + 7) / 8;
  localparam int PW  = NG * 8;

  logic              s1_valid_r;
  logic [NG-1:0][2:0] s1_gcnt_r;
  logic [NG-1:0]     s1_nz_r;
  logic              s2_valid_r;
  logic [CW-1:0]     s2_cnt_r;
  logic              s2_zero_r;

  logic              s1_adv_s;
  logic              s2_adv_s;
  logic [WIDTH-1:0]  z_s;
  logic [PW-1:0]     pad_s;
  logic [NG-1:0][2:0] gcnt_s;
  logic [NG-1:0]     nz_s;
  logic [CW-1:0]     cnt_s;
  logic              zero_s;

  function automatic logic [2:0] lz8(input logic [7:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i <= 7; i++) begin
      n = v[i] ? 3'(7 - i) : n;
    end
    return n;
  endfunction

  assign s2_adv_s     = !s2_valid_r || bus.out_ready;
  assign s1_adv_s     = !s1_valid_r || s2_adv_s;
  assign bus.in_ready = s1_adv_s;

  // Sign-bit counting becomes plain LZC of the bits below the MSB xor'ed with it;
  // the trailing sentinel 1 caps the count at WIDTH-1 for all-equal operands.
  generate
    if (SIGNED != 0) begin : g_sign
      assign z_s = {bus.in_data[WIDTH-2:0] ^ {(WIDTH-1){bus.in_data[WIDTH-1]}}, 1'b1};
    end else begin : g_unsigned
      assign z_s = bus.in_data;
    end
  endgenerate

  // Per-group counts; group 0 is the most significant, zero padding sits at the LSB end.
  always_comb begin
    pad_s = '0;
    pad_s[PW-1 -: WIDTH] = z_s;
    gcnt_s = '0;
    nz_s   = '0;
    for (int g = 0; g < NG; g++) begin
      gcnt_s[g] = lz8(pad_s[PW-1-8*g -: 8]);
      nz_s[g]   = |pad_s[PW-1-8*g -: 8];
    end
  end

  // Stage 1 registers group counts and nonzero flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_gcnt_r  <= '0;
      s1_nz_r    <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_gcnt_r <= gcnt_s;
        s1_nz_r   <= nz_s;
      end
    end
  end

  // First nonzero group wins: scanning from the least significant leaves the leading one.
  always_comb begin
    cnt_s = CW'(WIDTH);
    for (int g = NG - 1; g >= 0; g--) begin
      cnt_s = s1_nz_r[g] ? (CW'(g * 8) + CW'(s1_gcnt_r[g])) : cnt_s;
    end
    if (SIGNED != 0) begin
      zero_s = (cnt_s == CW'(WIDTH - 1));
    end else begin
      zero_s = (s1_nz_r == '0);
    end
  end

  // Stage 2 registers the combined count and degenerate flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r <= 1'b0;
      s2_cnt_r   <= '0;
      s2_zero_r  <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_cnt_r  <= cnt_s;
        s2_zero_r <= zero_s;
      end
    end
  end

  assign bus.out_valid = s2_valid_r;
  assign bus.out_cnt   = s2_cnt_r;
  assign bus.out_zero  = s2_zero_r;

`ifdef LZC_PIPE_NORM_EN
  logic [WIDTH-1:0] s1_data_r;
  logic [WIDTH-1:0] s2_norm_r;
  logic [WIDTH-1:0] norm_s;

  assign norm_s = s1_data_r << cnt_s;

  // Operand travels alongside the group counts for the stage-2 shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_r <= '0;
    end else if (s1_adv_s && bus.in_valid) begin
      s1_data_r <= bus.in_data;
    end
  end

  // Normalised operand register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_norm_r <= '0;
    end else if (s2_adv_s && s1_valid_r) begin
      s2_norm_r <= norm_s;
    end
  end

  assign bus.out_norm = s2_norm_r;
`else
  assign bus.out_norm = '0;
`endif

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed bench for lzc_pipe at several widths, both count modes, backpressure and reset.
// Expected out_norm values collapse to zero when LZC_PIPE_NORM_EN is not defined.
module tb_lzc_pipe;
  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  lzc_pipe_if #(.WIDTH(32)) b32 ();
  lzc_pipe_if #(.WIDTH(8))  b8 ();
  lzc_pipe_if #(.WIDTH(20)) b20 ();
  lzc_pipe_if #(.WIDTH(2))  b2 ();

  lzc_pipe #(.WIDTH(32), .SIGNED(0)) u32 (.clk(clk), .reset_n(reset_n), .bus(b32));
  lzc_pipe #(.WIDTH(8),  .SIGNED(1)) u8  (.clk(clk), .reset_n(reset_n), .bus(b8));
  lzc_pipe #(.WIDTH(20), .SIGNED(0)) u20 (.clk(clk), .reset_n(reset_n), .bus(b20));
  lzc_pipe #(.WIDTH(2),  .SIGNED(0)) u2  (.clk(clk), .reset_n(reset_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] nexp(input logic [63:0] v);
`ifdef LZC_PIPE_NORM_EN
    return v;
`else
    return 64'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [63:0] d);
    case (w)
      32: begin b32.in_valid = v; b32.in_data = d[31:0]; end
      8:  begin b8.in_valid  = v; b8.in_data  = d[7:0];  end
      20: begin b20.in_valid = v; b20.in_data = d[19:0]; end
      2:  begin b2.in_valid  = v; b2.in_data  = d[1:0];  end
      default: ;
    endcase
  endtask

  task automatic sample(input int w, output logic v, output logic [63:0] c,
                        output logic [63:0] z, output logic [63:0] n);
    v = 1'b0; c = 64'd0; z = 64'd0; n = 64'd0;
    case (w)
      32: begin v = b32.out_valid; c = 64'(b32.out_cnt); z = 64'(b32.out_zero); n = 64'(b32.out_norm); end
      8:  begin v = b8.out_valid;  c = 64'(b8.out_cnt);  z = 64'(b8.out_zero);  n = 64'(b8.out_norm);  end
      20: begin v = b20.out_valid; c = 64'(b20.out_cnt); z = 64'(b20.out_zero); n = 64'(b20.out_norm); end
      2:  begin v = b2.out_valid;  c = 64'(b2.out_cnt);  z = 64'(b2.out_zero);  n = 64'(b2.out_norm);  end
      default: ;
    endcase
  endtask

  // One transaction: present for one cycle, expect nothing after one edge, result after two.
  task automatic vec(input int w, input string tag, input logic [63:0] d,
                     input logic [63:0] c, input logic [63:0] z, input logic [63:0] n);
    logic v;
    logic [63:0] oc, oz, on;
    @(posedge clk); #1;
    drive(w, 1'b1, d);
    @(posedge clk); #1;
    drive(w, 1'b0, 64'd0);
    sample(w, v, oc, oz, on);
    check({tag, "_lat1_valid"}, 64'(v), 64'd0);
    @(posedge clk); #1;
    sample(w, v, oc, oz, on);
    check({tag, "_valid"}, 64'(v), 64'd1);
    check({tag, "_cnt"}, oc, c);
    check({tag, "_zero"}, oz, z);
    check({tag, "_norm"}, on, nexp(n));
  endtask

  logic [31:0] sd [8];
  logic [63:0] scnt [8];
  logic [63:0] snorm [8];
  int sent;
  int got;

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    drive(32, 1'b0, 64'd0); drive(8, 1'b0, 64'd0); drive(20, 1'b0, 64'd0); drive(2, 1'b0, 64'd0);
    b32.out_ready = 1'b1; b8.out_ready = 1'b1; b20.out_ready = 1'b1; b2.out_ready = 1'b1;

    #12;
    check("rst_out_valid", 64'(b32.out_valid), 64'd0);
    check("rst_in_ready", 64'(b32.in_ready), 64'd1);
    check("rst_out_cnt", 64'(b32.out_cnt), 64'd0);
    check("rst_in_ready8", 64'(b8.in_ready), 64'd1);
    reset_n = 1'b1;

    vec(32, "w32_bit16", 64'h0001_0000, 64'd15, 64'd0, 64'h8000_0000);
    vec(32, "w32_zero",  64'h0000_0000, 64'd32, 64'd1, 64'h0);
    vec(32, "w32_msb",   64'h8000_0000, 64'd0,  64'd0, 64'h8000_0000);
    vec(32, "w32_mid",   64'h0000_0A5C, 64'd20, 64'd0, 64'hA5C0_0000);
    vec(8,  "s8_f0",     64'hF0, 64'd3, 64'd0, 64'h80);
    vec(8,  "s8_0f",     64'h0F, 64'd3, 64'd0, 64'h78);
    vec(8,  "s8_ff",     64'hFF, 64'd7, 64'd1, 64'h80);
    vec(8,  "s8_00",     64'h00, 64'd7, 64'd1, 64'h00);
    vec(8,  "s8_40",     64'h40, 64'd0, 64'd0, 64'h40);
    vec(20, "w20_3",     64'h0_0003, 64'd18, 64'd0, 64'hC_0000);
    vec(20, "w20_zero",  64'h0_0000, 64'd20, 64'd1, 64'h0);
    vec(2,  "w2_0",      64'd0, 64'd2, 64'd1, 64'd0);
    vec(2,  "w2_1",      64'd1, 64'd1, 64'd0, 64'd2);
    vec(2,  "w2_2",      64'd2, 64'd0, 64'd0, 64'd2);
    vec(2,  "w2_3",      64'd3, 64'd0, 64'd0, 64'd3);

    // Streaming with a four-cycle consumer stall.
    for (int k = 0; k < 8; k++) begin
      sd[k]    = 32'hC000_0001 >> (3 * k);
      scnt[k]  = 64'(3 * k);
      snorm[k] = (k == 0) ? 64'hC000_0001 : 64'hC000_0000;
    end
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      b32.in_valid  = (sent < 8);
      b32.in_data   = (sent < 8) ? sd[sent] : 32'd0;
      b32.out_ready = !(c >= 3 && c <= 6);
      #1;
      if (c == 3) check("stream_stall_in_ready", 64'(b32.in_ready), 64'd0);
      if (c == 7) check("stream_resume_in_ready", 64'(b32.in_ready), 64'd1);
      if (b32.out_valid) begin
        if (got < 8) begin
          check($sformatf("stream_cnt%0d", got), 64'(b32.out_cnt), scnt[got]);
          check($sformatf("stream_norm%0d", got), 64'(b32.out_norm), nexp(snorm[got]));
          if (b32.out_ready) got++;
        end else begin
          check("stream_extra_result", 64'(b32.out_valid), 64'd0);
        end
      end
      if (b32.in_valid && b32.in_ready) sent++;
    end
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    check("stream_sent", 64'(sent), 64'd8);
    check("stream_got", 64'(got), 64'd8);

    // Reset with one result presented and another in stage 1.
    @(posedge clk); #1;
    drive(32, 1'b1, 64'h0001_0000);
    @(posedge clk); #1;
    drive(32, 1'b1, 64'h0000_0100);
    @(posedge clk); #1;
    drive(32, 1'b0, 64'd0);
    check("pre_rst_valid", 64'(b32.out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(b32.out_valid), 64'd0);
    check("rst_mid_cnt", 64'(b32.out_cnt), 64'd0);
    check("rst_mid_norm", 64'(b32.out_norm), 64'd0);
    check("rst_mid_in_ready", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_idle%0d", c), 64'(b32.out_valid), 64'd0);
    end
    vec(32, "post_rst", 64'h0000_0100, 64'd23, 64'd0, 64'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
